// File: rtl/corg_pkg.sv
// Shared definitions for the instruction-memory loader slice.
// Holds the loader FSM state type and the default memory geometry.
package corg_pkg;

    localparam int unsigned IMEM_ADDR_W = 8;
    localparam int unsigned INSTR_W     = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLenHi  = 3'd1,
        StLenLo  = 3'd2,
        StDataHi = 3'd3,
        StDataLo = 3'd4,
        StDone   = 3'd5,
        StErr    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bundle: control (start), byte stream (valid/ready/data), instruction
// memory write port and status outputs.
//   master : loader side (drives ready, write port and status)
//   slave  : environment side (drives start and the byte stream)
interface imem_loader_if
    import corg_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
);

    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

    modport slave (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

endinterface

// File: rtl/imem_loader_byte_pair_packer.sv
// Latches the high byte of an instruction and presents {hi, lo} combinationally.
//   clk, rst   : clock and synchronous active-high reset
//   load_hi_i  : capture byte_i as the high byte
//   byte_i     : stream byte (high byte when loading, low byte otherwise)
//   word_o     : {latched high byte, byte_i}
module byte_pair_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_hi_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] word_o
);

    logic [7:0] hi_q, hi_d;

    always_comb begin
        hi_d = hi_q;
        if (load_hi_i) begin
            hi_d = byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= 8'h00;
        end else begin
            hi_q <= hi_d;
        end
    end

    assign word_o = {hi_q, byte_i};

endmodule

// File: rtl/instruction_memory.sv
// Simple instruction memory: one synchronous write port, one combinational
// read port addressed by pc. Contents are not reset.
//   clk         : clock
//   we/waddr/wdata : write port
//   pc          : read word address
//   instruction : word at pc
module instruction_memory
    import corg_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign instruction = mem_q[pc];

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed big-endian byte stream, packs byte
// pairs into instructions and writes them to consecutive words from 0.
//   clk, rst : clock and synchronous active-high reset
//   bus      : start, byte stream (valid/ready/data), memory write port
//              (mem_we/mem_addr/mem_wdata) and status (cpu_hold/busy/done/error)
module imem_loader
    import corg_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);

    // Counter is one bit wider than the address so a full 2^ADDR_W load ends
    // without wrapping.
    localparam int unsigned     CntW   = ADDR_W + 1;
    localparam logic [16:0]     LenMax = 17'(1) << ADDR_W;
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    loader_state_t     state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [CntW-1:0]   len_q, len_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              in_load;
    logic              accept;
    logic              load_hi;
    logic [15:0]       len_full;
    logic [15:0]       word;
    logic [CntW-1:0]   cnt_inc;

    assign in_load  = (state_q == StLenHi) || (state_q == StLenLo) ||
                      (state_q == StDataHi) || (state_q == StDataLo);
    assign accept   = bus.byte_valid && in_load;
    assign load_hi  = accept && (state_q == StDataHi);
    assign len_full = {len_hi_q, bus.byte_data};
    assign cnt_inc  = cnt_q + CntOne;

    byte_pair_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .load_hi_i (load_hi),
        .byte_i    (bus.byte_data),
        .word_o    (word)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.start) begin
                    state_d = StLenHi;
                    cnt_d   = '0;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = bus.byte_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    if (len_full == 16'h0000) begin
                        state_d = StDone;
                    end else if ({1'b0, len_full} > LenMax) begin
                        state_d = StErr;
                    end else begin
                        len_d   = len_full[CntW-1:0];
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = DATA_W'(word);
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? StDone : StDataHi;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            len_hi_q <= 8'h00;
            len_q    <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.byte_ready = in_load;
    assign bus.busy       = in_load;
    assign bus.cpu_hold   = in_load;
    assign bus.done       = (state_q == StDone);
    assign bus.error      = (state_q == StErr);
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pc;
    logic [15:0] instruction;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instruction_memory #(.ADDR_W(8), .DATA_W(16)) u_mem (
        .clk         (clk),
        .we          (bus.mem_we),
        .waddr       (bus.mem_addr),
        .wdata       (bus.mem_wdata),
        .pc          (pc),
        .instruction (instruction)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_we    = 0;
    logic [7:0] last_we_addr = 8'h00;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Stream-level model: counts accepted bytes of the current load and
    // derives what the loader must show in the following cycle.
    localparam int MIdle = 0, MLoad = 1, MDone = 2, MErr = 3;
    int          m_mode  = MIdle;
    int          m_nb    = 0;
    int          m_n     = 0;
    int          m_words = 0;
    logic [7:0]  m_lenhi = 8'h00;
    logic [7:0]  m_hi    = 8'h00;
    logic        m_we    = 1'b0;
    logic [7:0]  m_addr  = 8'h00;
    logic [15:0] m_wdata = 16'h0000;
    logic [15:0] exp_mem [256];

    always @(posedge clk) begin : model
        automatic int          mode  = m_mode;
        automatic int          nb    = m_nb;
        automatic int          n     = m_n;
        automatic int          words = m_words;
        automatic logic [7:0]  lenhi = m_lenhi;
        automatic logic [7:0]  hi    = m_hi;
        automatic logic        we    = 1'b0;
        automatic logic [7:0]  addr  = m_addr;
        automatic logic [15:0] wdata = m_wdata;
        if (rst) begin
            mode  = MIdle;
            addr  = 8'h00;
            wdata = 16'h0000;
        end else if (mode != MLoad) begin
            if (bus.start) begin
                mode  = MLoad;
                nb    = 0;
                words = 0;
            end
        end else if (bus.byte_valid) begin
            if (nb == 0) begin
                lenhi = bus.byte_data;
            end else if (nb == 1) begin
                n = {16'h0000, lenhi, bus.byte_data};
                if (n == 0) mode = MDone;
                else if (n > 256) mode = MErr;
            end else if (nb % 2 == 0) begin
                hi = bus.byte_data;
            end else begin
                we    = 1'b1;
                addr  = words[7:0];
                wdata = {hi, bus.byte_data};
                exp_mem[words] <= {hi, bus.byte_data};
                words++;
                if (words == n) mode = MDone;
            end
            nb++;
        end
        m_mode  <= mode;
        m_nb    <= nb;
        m_n     <= n;
        m_words <= words;
        m_lenhi <= lenhi;
        m_hi    <= hi;
        m_we    <= we;
        m_addr  <= addr;
        m_wdata <= wdata;
    end

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("byte_ready", bus.byte_ready, m_mode == MLoad);
            check("busy", bus.busy, m_mode == MLoad);
            check("cpu_hold", bus.cpu_hold, m_mode == MLoad);
            check("done", bus.done, m_mode == MDone);
            check("error", bus.error, m_mode == MErr);
            check("mem_we", bus.mem_we, m_we);
            check("mem_wdata", bus.mem_wdata, m_wdata);
            if (m_we) check("mem_addr", bus.mem_addr, m_addr);
            if (bus.mem_we) begin
                n_we         <= n_we + 1;
                last_we_addr <= bus.mem_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) tick();
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.byte_ready, 0);
        check({tag, "_we"}, bus.mem_we, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
        check({tag, "_hold"}, bus.cpu_hold, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_error"}, bus.error, 0);
    endtask

    task automatic readback(input logic [7:0] a, input logic [15:0] exp, input string tag);
        pc = a;
        #1;
        check(tag, instruction, exp);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time %0t reached, bench did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int gap;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        pc             = 8'h00;
        rst            = 1'b1;
        repeat (2) tick();
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Idle: bytes offered but never accepted.
        check_all_zero("reset");
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        repeat (5) tick();
        check_all_zero("idle5");
        bus.byte_valid = 1'b0;

        // Two-word load.
        base = n_we;
        pulse_start();
        check("start_busy", bus.busy, 1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        check("last_strobe", {bus.mem_we, bus.done, bus.busy, bus.cpu_hold}, 4'b1100);
        check("last_addr", bus.mem_addr, 8'h01);
        check("last_wdata", bus.mem_wdata, 16'hABCD);
        repeat (2) tick();
        check("two_word_count", n_we - base, 2);
        readback(8'h00, 16'h1234, "rb_two_0");
        readback(8'h01, 16'hABCD, "rb_two_1");

        // Empty load, then oversize length.
        base = n_we;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tick();
        check("empty_done", bus.done, 1);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("len257_error", bus.error, 1);
        check("len257_ready", bus.byte_ready, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        repeat (3) tick();
        bus.byte_valid = 1'b0;
        check("no_writes_empty_err", n_we - base, 0);

        // Full 256-word load with random valid gaps.
        base = n_we;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_word(16'(i) ^ 16'hA5A5, gap);
        end
        repeat (2) tick();
        check("full_count", n_we - base, 256);
        check("full_last_addr", last_we_addr, 8'hFF);
        check("full_done", bus.done, 1);
        for (int i = 0; i < 256; i++) begin
            readback(8'(i), 16'(i) ^ 16'hA5A5, "rb_full");
            check("rb_full_model", instruction, exp_mem[i]);
        end

        // Reset mid-load, with the 4th word's low byte pending.
        base = n_we;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        send_word(16'h3333, 0);
        send_byte(8'h44, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h44;
        rst            = 1'b1;
        tick();
        rst            = 1'b0;
        bus.byte_valid = 1'b0;
        check_all_zero("midrst");
        tick();
        check("midrst_count", n_we - base, 3);
        readback(8'h00, 16'h1111, "rb_rst_0");
        readback(8'h01, 16'h2222, "rb_rst_1");
        readback(8'h02, 16'h3333, "rb_rst_2");
        readback(8'h03, 16'hA5A6, "rb_rst_3_untouched");

        // Reload after reset.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(16'hBEEF, 1);
        repeat (2) tick();
        check("reload_done", bus.done, 1);
        readback(8'h00, 16'hBEEF, "rb_reload_0");
        readback(8'h01, 16'h2222, "rb_reload_1");

        // Reset and start together: reset wins.
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);
        check("rst_start_done", bus.done, 0);

        // Start pulses mid-load are ignored.
        base = n_we;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(16'hCAFE, 0);
        pulse_start();
        send_word(16'hF00D, 0);
        pulse_start();
        send_word(16'h0123, 0);
        repeat (2) tick();
        check("midstart_count", n_we - base, 3);
        check("midstart_done", bus.done, 1);
        readback(8'h00, 16'hCAFE, "rb_mid_0");
        readback(8'h01, 16'hF00D, "rb_mid_1");
        readback(8'h02, 16'h0123, "rb_mid_2");

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
